// File: rtl/fetch_pc_unit.sv
// Fetch PC register and instruction-fetch front end: one outstanding memory request,
// small in-order instruction FIFO toward decode, redirect flush with wrong-path drop.
module fetch_pc_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] PC_STEP   = 16'd2,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [15:0] imem_rdata,
   output logic        instr_valid,
   output logic [15:0] instr_out,
   output logic [15:0] pc_out,
   output logic [15:0] pc_inc_out
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {StRun, StWait, StDrain} state_e;

   state_e            state_q, state_d;
   logic [15:0]       fetch_pc_q, fetch_pc_d;
   logic [15:0]       req_pc_q, req_pc_d;
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  in_flight;
   logic [15:0]       instr_mem_q [BUF_DEPTH];
   logic [15:0]       pc_mem_q    [BUF_DEPTH];
   logic              credit_ok, can_issue, accept, push, pop;

   // A kept request in flight reserves a FIFO slot; a same-cycle pop is not credited.
   always_comb begin
      in_flight = (state_q == StWait) ? CNT_W'(1) : '0;
      credit_ok = (count_q + in_flight) < CNT_W'(BUF_DEPTH);
      can_issue = (state_q == StRun) || ((state_q == StWait) && imem_rvalid);
      imem_req  = rst_n && !redirect && credit_ok && can_issue;
      accept    = imem_req && imem_ready;
      push      = !redirect && (state_q == StWait) && imem_rvalid;
      pop       = instr_valid && !stall && !redirect;
      if (redirect) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         unique case (state_q)
            StWait, StDrain: state_d = imem_rvalid ? StRun : StDrain;
            default:         state_d = StRun;
         endcase
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            req_pc_d   = fetch_pc_q;
         end
         unique case (state_q)
            StRun:   if (accept) state_d = StWait;
            StWait:  if (imem_rvalid) state_d = accept ? StWait : StRun;
            StDrain: if (imem_rvalid) state_d = StRun;
            default: state_d = StRun;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StRun;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i]    <= '0;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         count_q    <= count_d;
         if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) begin
               instr_mem_q[wr_ptr_q] <= imem_rdata;
               pc_mem_q[wr_ptr_q]    <= req_pc_q;
               wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
         end
      end
   end

   assign imem_addr   = fetch_pc_q;
   assign instr_valid = (count_q != '0);
   assign instr_out   = instr_mem_q[rd_ptr_q];
   assign pc_out      = pc_mem_q[rd_ptr_q];
   assign pc_inc_out  = pc_out + PC_STEP;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit: memory model with variable latency and readiness,
// program-order reference of delivered PCs, directed redirect/reset corner cases.
module tb_fetch_pc_unit;

   localparam logic [15:0] RESET_PC  = 16'h0000;
   localparam logic [15:0] PC_STEP   = 16'd2;
   localparam int unsigned BUF_DEPTH = 2;

   logic        clk, rst_n, redirect, stall;
   logic [15:0] redirect_pc;
   logic        imem_req, imem_ready, imem_rvalid, instr_valid;
   logic [15:0] imem_addr, imem_rdata, instr_out, pc_out, pc_inc_out;

   fetch_pc_unit #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP),
      .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .instr_valid(instr_valid),
      .instr_out  (instr_out),
      .pc_out     (pc_out),
      .pc_inc_out (pc_inc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C96;
   endfunction

   // Memory model: in-order responses, each tagged with the fetch epoch it belongs to.
   logic [15:0] pend_addr[$];
   int unsigned pend_due[$];
   int unsigned pend_epoch[$];
   bit          pend_stale[$];

   int unsigned cyc = 0;
   int unsigned epoch = 0;
   int          occ = 0;
   logic [15:0] exp_pc, exp_fetch;
   int unsigned ready_pct = 100, lat_min = 1, lat_max = 1;
   bit          redir_on_rvalid = 0, last_redir = 0, chk_no_req = 0;
   bit          prev_hold = 0, prev_redir_free = 0, first_after_reset = 0;
   logic [15:0] prev_pc, prev_instr;

   task automatic step(input bit redir, input logic [15:0] rpc, input bit st);
      bit rv, kept, acc, pp, do_redir, hold;
      logic [15:0] exp_inc;
      rv       = (pend_due.size() > 0) && (pend_due[0] <= cyc);
      do_redir = redir || (redir_on_rvalid && rv);
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(pend_addr[0]) : 16'($urandom);
      imem_ready  = ($urandom_range(99) < ready_pct) && ((pend_due.size() == 0) || rv);
      redirect    = do_redir;
      redirect_pc = rpc;
      stall       = st;
      #2;
      if (prev_redir_free && !do_redir) check_eq("redir_next_req", imem_req, 1);
      if (prev_hold) begin
         check_eq("stall_valid", instr_valid, 1);
         check_eq("stall_pc", pc_out, prev_pc);
         check_eq("stall_instr", instr_out, prev_instr);
      end
      if (do_redir) check_eq("redir_no_req", imem_req, 0);
      if ((pend_due.size() > 0) && !rv && !pend_stale[0]) check_eq("one_outstanding", imem_req, 0);
      if (imem_req) check_eq("fetch_addr", imem_addr, exp_fetch);
      check_eq("valid", instr_valid, occ > 0);
      check_eq("occ_bound", occ <= int'(BUF_DEPTH), 1);
      if (occ > 0) begin
         exp_inc = exp_pc + PC_STEP;
         check_eq("head_pc", pc_out, exp_pc);
         check_eq("head_instr", instr_out, mem_word(exp_pc));
         check_eq("head_pc_inc", pc_inc_out, exp_inc);
         if (first_after_reset) begin
            check_eq("first_pc_after_reset", pc_out, RESET_PC);
            first_after_reset = 0;
         end
      end
      if (chk_no_req) begin
         check_eq("full_no_req", imem_req, 0);
         check_eq("full_valid", instr_valid, 1);
      end
      acc  = imem_req && imem_ready;
      pp   = (occ > 0) && !st && !do_redir;
      hold = (occ > 0) && st && !do_redir;
      kept = rv && (pend_epoch[0] == epoch) && !do_redir;
      if (rv) begin
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
         void'(pend_epoch.pop_front());
         void'(pend_stale.pop_front());
      end
      if (acc) begin
         pend_addr.push_back(exp_fetch);
         pend_due.push_back(cyc + $urandom_range(lat_max, lat_min));
         pend_epoch.push_back(epoch);
         pend_stale.push_back(1'b0);
      end
      if (do_redir) begin
         occ = 0;
         exp_pc = rpc;
         exp_fetch = rpc;
         epoch++;
         first_after_reset = 0;
      end else begin
         occ = occ + int'(kept) - int'(pp);
         if (pp) exp_pc = exp_pc + PC_STEP;
         if (acc) exp_fetch = exp_fetch + PC_STEP;
      end
      last_redir      = do_redir;
      prev_redir_free = do_redir && (pend_due.size() == 0);
      prev_hold       = hold;
      prev_pc         = pc_out;
      prev_instr      = instr_out;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int unsigned n);
      rst_n = 1'b0;
      redirect = 1'b0;
      stall = 1'b0;
      imem_ready = 1'b0;
      imem_rvalid = 1'b0;
      #2;
      check_eq("rst_req", imem_req, 0);
      check_eq("rst_valid", instr_valid, 0);
      check_eq("rst_instr", instr_out, 0);
      check_eq("rst_pc", pc_out, 0);
      check_eq("rst_pc_inc", pc_inc_out, PC_STEP);
      check_eq("rst_addr", imem_addr, RESET_PC);
      occ = 0;
      exp_pc = RESET_PC;
      exp_fetch = RESET_PC;
      epoch++;
      foreach (pend_stale[i]) pend_stale[i] = 1'b1;
      prev_hold = 0;
      prev_redir_free = 0;
      first_after_reset = 1;
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      redirect = 1'b0;
      redirect_pc = '0;
      stall = 1'b0;
      imem_ready = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      #1;
      do_reset(2);

      // Straight-line fetch with 1-cycle memory.
      repeat (12) step(0, 16'h0, 0);

      // Long stall fills the buffer and blocks requests.
      repeat (5) step(0, 16'h0, 1);
      chk_no_req = 1;
      step(0, 16'h0, 1);
      chk_no_req = 0;
      repeat (6) step(0, 16'h0, 0);

      // Redirect with a slow request outstanding.
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 20 && pend_due.size() == 0; i++) step(0, 16'h0, 0);
      check_eq("t3_outstanding", pend_due.size() > 0, 1);
      step(1, 16'h0040, 0);
      repeat (15) step(0, 16'h0, 0);

      // Redirect in the same cycle as a response.
      lat_min = 2; lat_max = 2;
      redir_on_rvalid = 1;
      for (int i = 0; i < 20 && !last_redir; i++) step(0, 16'h0100, 0);
      redir_on_rvalid = 0;
      check_eq("t4_redirect_hit", last_redir, 1);
      repeat (12) step(0, 16'h0, 0);

      // Wrap at the top of the address space.
      lat_min = 1; lat_max = 1;
      step(1, 16'hFFFE, 0);
      repeat (10) step(0, 16'h0, 0);

      // Reset while a request is outstanding; its response arrives after release.
      lat_min = 4; lat_max = 4;
      for (int i = 0; i < 20 && pend_due.size() == 0; i++) step(0, 16'h0, 0);
      check_eq("t6_outstanding", pend_due.size() > 0, 1);
      do_reset(1);
      repeat (15) step(0, 16'h0, 0);

      // Random traffic.
      ready_pct = 70; lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] tgt;
         int unsigned sel;
         sel = $urandom_range(2);
         tgt = (sel == 0) ? 16'hFFFE : (sel == 1) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
         if ($urandom_range(999) < 2) begin
            do_reset($urandom_range(2, 1));
         end else begin
            step($urandom_range(99) < 5, tgt, $urandom_range(99) < 30);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
